sprite_ram_writer: RTL and testbench
====================================

// Module: sprite_ram_writer
// PURPOSE
//  Writer side of the sprite memory path: accepts a raster-order pixel stream (valid/ready)
//  and writes it into the 8-bit sprite RAM write port that the per-pixel sprite reader scans.
//  Sits between the sprite loader (UART/host DMA) and the dual-port sprite RAM; one frame per start.
// PARAMETERS
//  IMG_W        150     row stride of sprite memory in pixels
//  IMG_H        157     rows of sprite memory
//  ADDR_W       15      memory address width (IMG_W*IMG_H must be <= 2**ADDR_W)
//  TRANSPARENT  8'hE3   colour key treated as transparent by the reader
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous reset, active-low
//  start      in   1       1-cycle pulse: begin frame using cfg_w/cfg_h
//  cfg_w      in   10      sprite width in pixels, 1..IMG_W
//  cfg_h      in   10      sprite height in pixels, 1..IMG_H
//  in_valid   in   1       pixel stream valid
//  in_data    in   8       pixel colour (RRRGGGBB)
//  in_ready   out  1       writer can accept a pixel
//  mem_we     out  1       RAM write enable
//  mem_addr   out  ADDR_W  RAM write address
//  mem_data   out  8       RAM write data
//  busy       out  1       frame in progress
//  done       out  1       1-cycle pulse: last pixel written
//  err        out  1       1-cycle pulse: start rejected (bad dimensions)
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): all outputs 0, FSM->IDLE, counters 0; wins over every input,
//    aborts a frame mid-way (partial RAM contents left as-is, no done pulse).
//  - FSM: IDLE -> WRITE on start with 1<=cfg_w<=IMG_W and 1<=cfg_h<=IMG_H (dims latched);
//    invalid dims -> err=1 next cycle, stay IDLE. WRITE -> DONE after last handshake;
//    DONE -> IDLE after one cycle (done=1 during DONE). start outside IDLE is ignored.
//  - in_ready = 1 only in WRITE (combinational from state); handshake = in_valid & in_ready.
//  - Per handshake: mem_we=1, mem_data=in_data, mem_addr=row*IMG_W+col on the next cycle
//    (1-cycle registered latency); mem_we=0 on cycles without handshake.
//  - Address generated incrementally: col+1/addr+1 per pixel; at col==w_lat-1 col->0,
//    row+1, addr=row_base+IMG_W (row_base register). No multiplier.
//  - Last pixel: row==h_lat-1 & col==w_lat-1 handshake -> in_ready drops next cycle.
//  - Pixel count per frame is exactly w_lat*h_lat; max address IMG_W*IMG_H-1, never wraps.
//  - busy = 1 in WRITE and DONE.
// CONFIGURATION
//  SPRITE_WR_SKIP_TRANSPARENT_EN defined: pixels equal to TRANSPARENT are consumed
//    (handshake, counters advance) but mem_we stays 0 -> existing RAM contents kept.
//  Undefined: every accepted pixel is written, including TRANSPARENT.
// STRUCTURE
//  Shared package sprite_pkg: IMG_W/IMG_H/ADDR_W defaults, TRANSPARENT colour,
//    pixel typedef (8-bit), FSM state enum {IDLE, WRITE, DONE}.
//  One sub-module natural: sprite_raster_counter (col/row/addr/row_base, last flag).
// TESTING
//  1. start, w=3,h=2, continuous valid data 1..6 -> mem writes addr 0,1,2,150,151,152 data 1..6,
//     done pulse one cycle after final write, busy low after.
//  2. Same with in_valid toggling every other cycle -> identical write sequence, no gaps misaddressed.
//  3. start with w=0, then w=151 -> err pulse each, in_ready stays 0, no mem_we.
//  4. rst=0 after 4 of 6 pixels -> outputs 0 next cycle, IDLE; new start w=2,h=1 writes addr 0,1.
//  5. w=150,h=157 full frame -> last addr 23549, exactly 23550 writes, done once.
//  6. Macro defined, data pattern 5,E3,7 (w=3,h=1) -> writes addr 0 and 2 only; undefined -> 3 writes.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite-memory constants, pixel type and writer FSM state encoding.
package sprite_pkg;

    localparam int unsigned IMG_W  = 150;
    localparam int unsigned IMG_H  = 157;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DIM_W  = 10;
    localparam int unsigned PIX_W  = 8;

    typedef logic [PIX_W-1:0] pixel_t;

    localparam pixel_t TRANSPARENT = 8'hE3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Requested sprite must be non-empty and fit inside the memory image.
    function automatic logic dims_ok(input logic [DIM_W-1:0] w, input logic [DIM_W-1:0] h);
        return (w != '0) && (w <= DIM_W'(IMG_W)) && (h != '0) && (h <= DIM_W'(IMG_H));
    endfunction

endpackage

// File: rtl/sprite_raster_counter.sv
// Raster position tracker: column/row plus an incrementally built RAM address.
module sprite_raster_counter
    import sprite_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    input  logic [DIM_W-1:0]  w_lat,
    input  logic [DIM_W-1:0]  h_lat,
    output logic [ADDR_W-1:0] addr,
    output logic              last_c
);

    logic [DIM_W-1:0]  col;
    logic [DIM_W-1:0]  row;
    logic [ADDR_W-1:0] row_base;

    assign last_c = (col == w_lat - DIM_W'(1)) && (row == h_lat - DIM_W'(1));

    // End of a row jumps to the next memory row via row_base, avoiding a multiplier.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            col      <= '0;
            row      <= '0;
            addr     <= '0;
            row_base <= '0;
        end else if (advance) begin
            if (col == w_lat - DIM_W'(1)) begin
                col      <= '0;
                row      <= row + DIM_W'(1);
                row_base <= row_base + ADDR_W'(IMG_W);
                addr     <= row_base + ADDR_W'(IMG_W);
            end else begin
                col  <= col + DIM_W'(1);
                addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_ram_writer.sv
// Writes one raster-order sprite frame per start into the sprite RAM write port.
// Optional: SPRITE_WR_SKIP_TRANSPARENT_EN suppresses writes of the transparent colour key.
module sprite_ram_writer
    import sprite_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic              in_valid,
    input  logic [PIX_W-1:0]  in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state;
    logic [DIM_W-1:0]  w_lat;
    logic [DIM_W-1:0]  h_lat;
    logic [ADDR_W-1:0] cur_addr;
    logic              last_c;
    logic              hs_c;
    logic              accept_c;
    logic              write_c;

    assign in_ready = (state == WRITE);
    assign hs_c     = in_valid & in_ready;
    assign accept_c = (state == IDLE) & start & dims_ok(cfg_w, cfg_h);

`ifdef SPRITE_WR_SKIP_TRANSPARENT_EN
    assign write_c = hs_c & (in_data != TRANSPARENT);
`else
    assign write_c = hs_c;
`endif

    sprite_raster_counter u_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept_c),
        .advance (hs_c),
        .w_lat   (w_lat),
        .h_lat   (h_lat),
        .addr    (cur_addr),
        .last_c  (last_c)
    );

    // Frame sequencing; pulses default low and are raised for a single cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            w_lat    <= '0;
            h_lat    <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        w_lat <= cfg_w;
                        h_lat <= cfg_h;
                        busy  <= 1'b1;
                        state <= WRITE;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                WRITE: begin
                    if (hs_c) begin
                        mem_we   <= write_c;
                        mem_addr <= cur_addr;
                        mem_data <= in_data;
                        if (last_c) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Directed self-checking bench for sprite_ram_writer.
module tb_sprite_ram_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  cfg_w;
    logic [9:0]  cfg_h;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [7:0]  mem_data;
    logic        busy;
    logic        done;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    logic [14:0] q_addr[$];
    logic [7:0]  q_data[$];

    always #5 clk = ~clk;

    sprite_ram_writer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_w    (cfg_w),
        .cfg_h    (cfg_h),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Record every RAM write and pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            q_addr.push_back(mem_addr);
            q_data.push_back(mem_data);
        end
        if (done) done_cnt++;
        if (err)  err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic pulse_start(input int w, input int h);
        start = 1'b1;
        cfg_w = 10'(w);
        cfg_h = 10'(h);
        step();
        start = 1'b0;
    endtask

    // Stream w*h pixels (data = idx%200+1, never the colour key); optional every-other-cycle gaps.
    task automatic run_frame(input int w, input int h, input bit gappy, input int max_cyc);
        int  k   = 0;
        int  cyc = 0;
        logic hs;
        pulse_start(w, h);
        while (k < w * h && cyc < max_cyc) begin
            in_valid = gappy ? (cyc % 2 == 0) : 1'b1;
            in_data  = 8'((k % 200) + 1);
            hs = in_valid & in_ready;
            step();
            if (hs) k++;
            cyc++;
        end
        in_valid = 1'b0;
        check("frame_pixels_accepted", 32'(k), 32'(w * h));
        check("done_at_end", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        step();
        check("done_cleared", 32'(done), 32'd0);
        check("busy_cleared", 32'(busy), 32'd0);
        check("ready_after_frame", 32'(in_ready), 32'd0);
    endtask

    task automatic check_small_frame(input string tag);
        logic [14:0] exp_addr[6];
        exp_addr[0] = 15'd0;   exp_addr[1] = 15'd1;   exp_addr[2] = 15'd2;
        exp_addr[3] = 15'd150; exp_addr[4] = 15'd151; exp_addr[5] = 15'd152;
        check({tag, "_write_count"}, 32'(q_addr.size()), 32'd6);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        for (int i = 0; i < 6 && i < q_addr.size(); i++) begin
            check({tag, "_addr"}, 32'(q_addr[i]), 32'(exp_addr[i]));
            check({tag, "_data"}, 32'(q_data[i]), 32'(i + 1));
        end
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        cfg_w    = '0;
        cfg_h    = '0;
        in_valid = 1'b0;
        in_data  = '0;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        step();

        // 3x2 frame, continuous stream
        clear_log();
        run_frame(3, 2, 1'b0, 40);
        check_small_frame("cont");

        // 3x2 frame, valid toggling
        clear_log();
        run_frame(3, 2, 1'b1, 40);
        check_small_frame("gappy");

        // Rejected dimensions
        clear_log();
        pulse_start(0, 2);
        check("w0_err", 32'(err), 32'd1);
        check("w0_ready", 32'(in_ready), 32'd0);
        check("w0_busy", 32'(busy), 32'd0);
        step();
        check("w0_err_pulse", 32'(err), 32'd0);
        pulse_start(151, 2);
        check("w151_err", 32'(err), 32'd1);
        check("w151_ready", 32'(in_ready), 32'd0);
        pulse_start(3, 158);
        check("h158_err", 32'(err), 32'd1);
        step();
        check("bad_err_count", 32'(err_cnt), 32'd3);
        check("bad_no_writes", 32'(q_addr.size()), 32'd0);

        // Reset aborts a frame after four pixels
        clear_log();
        pulse_start(3, 2);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(i + 1);
            step();
        end
        rst = 1'b0;
        step();
        in_valid = 1'b0;
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_writes", 32'(q_addr.size()), 32'd4);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        rst = 1'b1;
        step();
        clear_log();
        run_frame(2, 1, 1'b0, 20);
        check("after_abort_count", 32'(q_addr.size()), 32'd2);
        if (q_addr.size() == 2) begin
            check("after_abort_a0", 32'(q_addr[0]), 32'd0);
            check("after_abort_a1", 32'(q_addr[1]), 32'd1);
        end

        // Full 150x157 frame
        clear_log();
        run_frame(150, 157, 1'b0, 23600);
        check("full_count", 32'(q_addr.size()), 32'd23550);
        check("full_done_count", 32'(done_cnt), 32'd1);
        if (q_addr.size() == 23550) begin
            check("full_last_addr", 32'(q_addr[23549]), 32'd23549);
            check("full_row1_addr", 32'(q_addr[150]), 32'd150);
            check("full_row1_data", 32'(q_data[150]), 32'd151);
            check("full_last_data", 32'(q_data[23549]), 32'd150);
        end

        // Transparent colour key handling, 3x1
        clear_log();
        pulse_start(3, 1);
        in_valid = 1'b1;
        in_data = 8'h05; step();
        in_data = 8'hE3; step();
        in_data = 8'h07; step();
        in_valid = 1'b0;
        step();
        step();
        check("key_done_count", 32'(done_cnt), 32'd1);
`ifdef SPRITE_WR_SKIP_TRANSPARENT_EN
        check("key_write_count", 32'(q_addr.size()), 32'd2);
`else
        check("key_write_count", 32'(q_addr.size()), 32'd3);
`endif
        if (q_addr.size() >= 2) begin
            check("key_first_addr", 32'(q_addr[0]), 32'd0);
            check("key_first_data", 32'(q_data[0]), 32'h05);
            check("key_last_addr", 32'(q_addr[q_addr.size() - 1]), 32'd2);
            check("key_last_data", 32'(q_data[q_data.size() - 1]), 32'h07);
        end

        // Start while busy is ignored
        clear_log();
        pulse_start(2, 1);
        pulse_start(0, 0);
        check("busy_start_no_err", 32'(err), 32'd0);
        check("busy_start_ready", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
